// File: rtl/operand_collector.sv
// operand_collector: single-slot collector that reads each source operand from the warp RF and issues the whole instruction. Build with OPC_SKIP_DUPLICATE_EN to read repeated indices only once.
// Latency: opc_valid_o rises OperandsPerInst+2 cycles after the dispatch handshake when the RF is always ready with 1-cycle reads.
// Backpressure: an RF stall holds the request and its index; eu_ready_i low holds the issue outputs and blocks dispatch.
module operand_collector #(
    parameter  int unsigned NumTags         = 8,
    parameter  int unsigned WarpWidth       = 32,
    parameter  int unsigned RegWidth        = 32,
    parameter  int unsigned RegIdxWidth     = 6,
    parameter  int unsigned OperandsPerInst = 2,
    localparam int unsigned TagWidth        = $clog2(NumTags)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    output logic                                          opc_ready_o,
    input  logic                                          disp_valid_i,
    input  logic [TagWidth-1:0]                           disp_tag_i,
    input  logic [RegIdxWidth-1:0]                        disp_dst_i,
    input  logic [OperandsPerInst*RegIdxWidth-1:0]        disp_operands_i,
    output logic                                          opc_rf_req_valid_o,
    input  logic                                          rf_req_ready_i,
    output logic [RegIdxWidth-1:0]                        opc_rf_req_idx_o,
    input  logic                                          rf_rsp_valid_i,
    input  logic [WarpWidth*RegWidth-1:0]                 rf_rsp_data_i,
    input  logic                                          eu_ready_i,
    output logic                                          opc_valid_o,
    output logic [TagWidth-1:0]                           opc_tag_o,
    output logic [RegIdxWidth-1:0]                        opc_dst_o,
    output logic [OperandsPerInst*WarpWidth*RegWidth-1:0] opc_operands_o
);

    localparam int unsigned     CntW   = $clog2(OperandsPerInst + 1);
    localparam int unsigned     OpW    = WarpWidth * RegWidth;
    localparam logic [CntW-1:0] CntMax = CntW'(OperandsPerInst);

    // Captured instruction header; operand index 0 sits in the LSBs.
    typedef struct packed {
        logic [TagWidth-1:0]                             tag;
        logic [RegIdxWidth-1:0]                          dst;
        logic [OperandsPerInst-1:0][RegIdxWidth-1:0]     idx;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_e;

    state_e                            state_q, state_d;
    hdr_t                              hdr_q;
    logic [OperandsPerInst-1:0][OpW-1:0] data_q;
    logic [CntW-1:0]                   req_cnt_q, rsp_cnt_q;
    logic [CntW-1:0]                   req_cnt_nxt, rsp_cnt_nxt;
    logic [OperandsPerInst-1:0]        needed;
    logic [OperandsPerInst-1:0]        wr_slot;
    logic [RegIdxWidth-1:0]            req_idx;
    logic                              disp_hs, req_hs, rsp_ok;

    // Next slot after cur that still has to be read; CntMax when none is left.
    function automatic logic [CntW-1:0] next_slot(input logic [CntW-1:0] cur,
                                                  input logic [OperandsPerInst-1:0] mask);
        logic [CntW-1:0] nxt;
        nxt = CntMax;
        for (int i = int'(OperandsPerInst) - 1; i >= 0; i--) begin
            if ((CntW'(i) > cur) && mask[i]) nxt = CntW'(i);
        end
        return nxt;
    endfunction

    assign disp_hs     = disp_valid_i && opc_ready_o;
    assign req_hs      = opc_rf_req_valid_o && rf_req_ready_i;
    // A response only counts while COLLECT has a request outstanding.
    assign rsp_ok      = rf_rsp_valid_i && (state_q == COLLECT) && (rsp_cnt_q != req_cnt_q);
    assign req_cnt_nxt = next_slot(req_cnt_q, needed);
    assign rsp_cnt_nxt = next_slot(rsp_cnt_q, needed);

    assign opc_rf_req_idx_o = req_idx;
    assign opc_tag_o        = hdr_q.tag;
    assign opc_dst_o        = hdr_q.dst;
    assign opc_operands_o   = data_q;

    // Needed mask: only the first occurrence of a repeated index is read when skipping is built in.
    always_comb begin
        needed = '1;
`ifdef OPC_SKIP_DUPLICATE_EN
        for (int i = 1; i < int'(OperandsPerInst); i++) begin
            for (int j = 0; j < i; j++) begin
                if (hdr_q.idx[i] == hdr_q.idx[j]) needed[i] = 1'b0;
            end
        end
`endif
    end

    // Request index mux; out-of-range counts leave it at zero while the request is idle.
    always_comb begin
        req_idx = '0;
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            if (req_cnt_q == CntW'(i)) req_idx = hdr_q.idx[i];
        end
    end

`ifdef OPC_SKIP_DUPLICATE_EN
    logic [RegIdxWidth-1:0] rsp_idx;

    // Response write enables: the responding slot plus every skipped copy of the same register.
    always_comb begin
        rsp_idx = '0;
        wr_slot = '0;
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            if (rsp_cnt_q == CntW'(i)) rsp_idx = hdr_q.idx[i];
        end
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            wr_slot[i] = (rsp_cnt_q == CntW'(i)) || (!needed[i] && (hdr_q.idx[i] == rsp_idx));
        end
    end
`else
    // Response write enables: only the slot the response belongs to.
    always_comb begin
        wr_slot = '0;
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            wr_slot[i] = (rsp_cnt_q == CntW'(i));
        end
    end
`endif

    // Next-state and handshake outputs.
    always_comb begin
        state_d            = state_q;
        opc_ready_o        = 1'b0;
        opc_valid_o        = 1'b0;
        opc_rf_req_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                opc_ready_o = 1'b1;
                if (disp_valid_i) state_d = COLLECT;
            end
            COLLECT: begin
                opc_rf_req_valid_o = (req_cnt_q < CntMax);
                if (rsp_ok && (rsp_cnt_nxt == CntMax)) state_d = ISSUE;
            end
            ISSUE: begin
                opc_valid_o = 1'b1;
                opc_ready_o = eu_ready_i;
                if (eu_ready_i) state_d = disp_valid_i ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Instruction capture, request/response counters and operand storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_q     <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            data_q    <= '0;
        end else if (disp_hs) begin
            hdr_q.tag <= disp_tag_i;
            hdr_q.dst <= disp_dst_i;
            hdr_q.idx <= disp_operands_i;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (req_hs) req_cnt_q <= req_cnt_nxt;
            if (rsp_ok) begin
                rsp_cnt_q <= rsp_cnt_nxt;
                for (int i = 0; i < int'(OperandsPerInst); i++) begin
                    if (wr_slot[i]) data_q[i] <= rf_rsp_data_i;
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic rsp_err;
    assign rsp_err = rf_rsp_valid_i && !rsp_ok;

    // A response with nothing outstanding is dropped by the datapath and flagged here.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!rsp_err) else $error("operand_collector: unexpected rf response");
        end
    end
`endif

endmodule
